// File: rtl/pc_pkg.sv
// Shared constants and the next-PC selection encoding for the fetch-stage PC sequencer.
package pc_pkg;

  localparam int          PC_XLEN          = 32;
  localparam logic [31:0] PC_RESET_VECTOR  = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VECTOR    = 32'h8000_0180;
  localparam int          PC_INSTR_BYTES   = 4;

  // Next-PC source, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    PC_SEL_EXC,
    PC_SEL_ERET,
    PC_SEL_HOLD,
    PC_SEL_RAS,
    PC_SEL_REDIR,
    PC_SEL_SEQ
  } pc_sel_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control inputs from branch/hazard logic and the sequencer's registered outputs.
interface pc_sequencer_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);

  logic                             stall;
  logic                             exc_req;
  logic                             eret;
  logic                             redirect_valid;
  logic [XLEN-1:0]                  redirect_target;
  logic                             call;
  logic                             ret;
  logic [XLEN-1:0]                  pc;
  logic [XLEN-1:0]                  epc;
  logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count;
  logic                             ras_underflow;

  modport master (
    output stall, exc_req, eret, redirect_valid, redirect_target, call, ret,
    input  pc, epc, ras_count, ras_underflow
  );

  modport slave (
    input  stall, exc_req, eret, redirect_valid, redirect_target, call, ret,
    output pc, epc, ras_count, ras_underflow
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. Oldest entry is overwritten on a push when
// full; push and pop together replace the top entry in place (tail call).
module pc_ras #(
  parameter  int XLEN      = 32,
  parameter  int RAS_DEPTH = 4,
  localparam int CW        = $clog2(RAS_DEPTH + 1),
  localparam int PW        = $clog2(RAS_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic [CW-1:0]   count
);

  logic [XLEN-1:0] entries [RAS_DEPTH];
  logic [PW-1:0]   ptr;

  assign top = entries[ptr];

  // Stack storage, top pointer and saturating occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) entries[i] <= '0;
      ptr   <= '0;
      count <= '0;
    end else if (push && pop) begin
      entries[ptr] <= push_data;
    end else if (push) begin
      entries[ptr + 1'b1] <= push_data;
      ptr                 <= ptr + 1'b1;
      if (count != CW'(RAS_DEPTH)) count <= count + 1'b1;
    end else if (pop) begin
      ptr <= ptr - 1'b1;
      if (count != '0) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Prioritised next-PC selector for the fetch stage: exception, eret, stall,
// RAS return, redirect, sequential.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(PC_EXC_VECTOR),
  parameter int              INSTR_BYTES  = PC_INSTR_BYTES,
  parameter int              RAS_DEPTH    = 4
) (
  input logic              clk,
  input logic              rst_n,
  pc_sequencer_if.slave    bus
);

  localparam int CW = $clog2(RAS_DEPTH + 1);

  pc_sel_t         sel;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] ras_top;
  logic [CW-1:0]   ras_count;
  logic            ras_push;
  logic            ras_pop;
  logic            ret_empty;

  assign pc_seq = bus.pc + XLEN'(INSTR_BYTES);

  // Next-PC priority encode and the RAS operations owned by the winning source.
  always_comb begin
    sel       = PC_SEL_SEQ;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ret_empty = 1'b0;
    if (bus.exc_req) begin
      sel = PC_SEL_EXC;
    end else if (bus.eret) begin
      sel = PC_SEL_ERET;
    end else if (bus.stall) begin
      sel = PC_SEL_HOLD;
    end else if (bus.ret && ras_count != '0) begin
      sel      = PC_SEL_RAS;
      ras_pop  = 1'b1;
      ras_push = bus.call;
    end else begin
      ret_empty = bus.ret;
      if (bus.redirect_valid) begin
        sel      = PC_SEL_REDIR;
        ras_push = bus.call && !bus.ret;
      end
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .count     (ras_count)
  );

  assign bus.ras_count = ras_count;

  // PC, EPC and the underflow pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pc            <= RESET_VECTOR;
      bus.epc           <= '0;
      bus.ras_underflow <= 1'b0;
    end else begin
      bus.ras_underflow <= ret_empty;
      unique case (sel)
        PC_SEL_EXC: begin
          bus.pc  <= EXC_VECTOR;
          bus.epc <= bus.pc;
        end
        PC_SEL_ERET:  bus.pc <= bus.epc;
        PC_SEL_HOLD:  bus.pc <= bus.pc;
        PC_SEL_RAS:   bus.pc <= ras_top;
        PC_SEL_REDIR: bus.pc <= bus.redirect_target;
        default:      bus.pc <= pc_seq;
      endcase
    end
  end

endmodule
